imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the 64x32 instruction memory. It fills the memory from a byte stream before the pipeline runs.
- Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words.
- Writes each word through the memory write port, then appends the halt sentinel 32'hFFFFFFFF so the fetch stage's pc_en deasserts at program end.
- Holds the CPU (cpu_hold) until a load completes without error.

Parameters:
- DEPTH, 64: instruction memory words; sets the maximum word count and address width.
- ADDR_W, 6: memory address width; equals log2(DEPTH).
- HALT_WORD, 32'hFFFFFFFF: terminator written after the last program word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- busy  out  1  load in progress (HDR, DATA or TERM).
- done  out  1  last load completed cleanly; sticky until the next start.
- err  out  1  last load aborted; sticky until the next start.
- cpu_hold  out  1  keep the pipeline in reset or stalled; 0 only in DONE.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1. Byte index and word counter clear to 0.
- A byte transfers on a rising edge with in_valid & in_ready. in_data is ignored when no transfer occurs.
- IDLE: in_ready=0. On start, go to HDR and clear done and err.
- HDR: in_ready=1.
  - The first transferred byte is the word count N.
  - N > DEPTH-1 (>63): go to ERR.
  - N = 0: go to TERM.
  - Otherwise latch N and go to DATA.
- DATA: in_ready=1 continuously; the block never back-pressures in DATA.
  - Byte k of each word goes to bits [8k+7:8k], k=0..3.
  - On the edge that accepts byte 3, the word is registered. In the next cycle mem_we=1, mem_addr=word index, mem_wdata=word, for one cycle.
  - Transfers may continue in that same cycle.
  - After word N-1 is accepted, go to TERM.
- TERM: in_ready=0. Exactly one cycle with mem_we=1, mem_addr=N, mem_wdata=HALT_WORD, then DONE.
  - If the last data-word write is still pending, it is issued first; the two writes occupy consecutive cycles and never overlap.
- DONE: done=1, cpu_hold=0, in_ready=0. On start, go to HDR and set cpu_hold=1 again.
- ERR: err=1, cpu_hold=1, in_ready=0; no memory writes. Exits only on start (to HDR) or rst.
- start while busy is ignored.
- Payload words equal to HALT_WORD are written as-is and not policed; execution simply stops there.
- Write latency: 1 cycle from acceptance of the 4th byte to mem_we.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-load aborts immediately. Memory contents already written are not scrubbed, and cpu_hold returns to 1.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - A CHK state follows DATA (or follows HDR when N=0) and accepts one more byte.
  - The expected checksum is the XOR of the header byte and all payload bytes.
  - Match: go to TERM. Mismatch: go to ERR; the terminator is not written, so the CPU stays held.
- Undefined: no checksum byte is expected and there is no CHK state.

Decomposition:
- Package imem_pkg holds:
  - constants IMEM_DEPTH=64, IMEM_ADDR_W=6, IMEM_HALT_WORD=32'hFFFFFFFF;
  - the loader state enum (IDLE, HDR, DATA, CHK, TERM, DONE, ERR).
- One sub-module, imem_word_packer: a 2-bit byte index plus a 32-bit shift/assemble register with a word_valid pulse.

Test Plan:
- rst then start, stream N=2, bytes 78 56 34 12 EF BE AD DE:
  - writes [0]=12345678, [1]=DEADBEEF, [2]=FFFFFFFF on three mem_we cycles;
  - then done=1, cpu_hold=0.
- start, N=0: exactly one write, [0]=FFFFFFFF; then done=1.
- start, header 0x40: err=1, cpu_hold=1, no mem_we ever asserts; a later start then N=1, bytes 01 00 00 00 recovers with [0]=00000001, [1]=FFFFFFFF.
- Back-to-back in_valid with no gaps for N=63: 63 data writes with addresses 0..62, then HALT at 63; in_ready never drops in DATA.
- rst asserted after 5 bytes of a load: all outputs take reset values asynchronously, before the next clk edge. start pulsed while busy has no effect.
- With IMEM_LOADER_CHECKSUM_EN, N=1, bytes 01 02 03 04:
  - checksum byte 0x05 (01^01^02^03^04) reaches done;
  - checksum 0x06 sets err and produces no HALT write.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the instruction-memory loader.
package imem_pkg;

  localparam int          IMEM_DEPTH     = 64;
  localparam int          IMEM_ADDR_W    = 6;
  localparam logic [31:0] IMEM_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_TERM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler; word_valid marks the byte that completes a word,
// with word presenting the fully assembled value in that same cycle.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      shift_q  <= {byte_in, shift_q[23:8]};
    end
  end

  // Bytes 0..2 sit in shift_q; the fourth byte is merged straight from the input.
  assign word_valid = byte_en && (byte_idx == 2'd3);
  assign word       = {byte_in, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: header count, packed words, halt sentinel.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
import imem_pkg::*;

module imem_loader #(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter logic [31:0] HALT_WORD = IMEM_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  loader_state_t     state;
  logic [ADDR_W-1:0] n_words;
  logic [ADDR_W-1:0] word_idx;
  logic              term_wr;
  logic              xfer;
  logic              start_ok;
  logic              pk_en;
  logic              pk_word_valid;
  logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign pk_en    = xfer && (state == ST_DATA);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_en    (pk_en),
    .byte_in    (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      n_words   <= '0;
      word_idx  <= '0;
      term_wr   <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_acc   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_HDR;
            word_idx <= '0;
            term_wr  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            n_words <= in_data[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= in_data;
`endif
            if (int'(in_data) > DEPTH - 1) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else if (in_data == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= ST_CHK;
`else
              state    <= ST_TERM;
              in_ready <= 1'b0;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ in_data;
`endif
            if (pk_word_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx;
              mem_wdata <= pk_word;
              word_idx  <= word_idx + ADDR_W'(1);
              if (word_idx == n_words - ADDR_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= ST_CHK;
`else
                state    <= ST_TERM;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end
        ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == chk_acc) begin
              state <= ST_TERM;
            end else begin
              state <= ST_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_TERM: begin
          // First TERM cycle carries any pending data write; the halt write follows in the second.
          if (!term_wr) begin
            term_wr   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= n_words;
            mem_wdata <= HALT_WORD;
          end else begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads against a byte-level model.
module tb_imem_loader;
  import imem_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int tests = 0;
  int fails = 0;
  wr_t got[$];
  wr_t exp_w[$];

  imem_loader #(
    .DEPTH     (64),
    .ADDR_W    (6),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_we) got.push_back('{a: mem_addr, d: mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: expected write list and outcome from the raw byte stream.
  task automatic model(input bq_t bq, output bit ok);
    int n;
    logic [7:0] x;
    exp_w.delete();
    n  = int'(bq[0]);
    ok = 1'b0;
    if (n > 63) return;
    for (int i = 0; i < n; i++)
      exp_w.push_back('{a: 6'(i), d: {bq[4*i+4], bq[4*i+3], bq[4*i+2], bq[4*i+1]}});
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i <= 4*n; i++) x = x ^ bq[i];
    ok = (bq[4*n+1] == x);
`else
    x  = 8'h00;
    ok = (x == 8'h00);
`endif
    if (ok) exp_w.push_back('{a: 6'(n), d: IMEM_HALT_WORD});
  endtask

  function automatic bq_t add_chk(input bq_t bq);
    bq_t r = bq;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (bq[i]) x = x ^ bq[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t bq, input int gap_pct, input int start_at, output int stalls);
    bit acc;
    stalls = 0;
    foreach (bq[i]) begin
      acc = 1'b0;
      for (int c = 0; c < 1000 && !acc; c++) begin
        start    = (i == start_at);
        in_valid = ($urandom_range(0, 99) >= gap_pct);
        in_data  = in_valid ? bq[i] : 8'($urandom);
        if (in_valid && !in_ready) stalls++;
        acc = in_valid && in_ready;
        @(negedge clk);
      end
      check("byte_accepted", 32'(acc), 32'd1);
      if (!acc) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_load(input string tag, input bq_t bq, input int gap_pct, input int start_at,
                          output int stalls);
    bit ok;
    int c;
    model(bq, ok);
    got.delete();
    pulse_start();
    send_bytes(bq, gap_pct, start_at, stalls);
    for (c = 0; c < 400; c++) begin
      if (done || err) break;
      @(negedge clk);
    end
    check({tag, "_finished"}, 32'(done || err), 32'd1);
    repeat (5) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      check({tag, "_addr"}, 32'(got[i].a), 32'(exp_w[i].a));
      check({tag, "_data"}, got[i].d, exp_w[i].d);
    end
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_err"}, 32'(err), 32'(!ok));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    if (exp_w.size() > 0) check({tag, "_addr_hold"}, 32'(mem_addr), 32'(exp_w[exp_w.size()-1].a));
  endtask

  initial begin
    bq_t bq;
    int  stalls;
    int  n;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    bq = add_chk('{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    run_load("n2", bq, 0, -1, stalls);

    bq = add_chk('{8'h00});
    run_load("n0", bq, 0, -1, stalls);

    bq = '{8'h40};
    run_load("hdr40", bq, 0, -1, stalls);
    repeat (10) @(negedge clk);
    check("hdr40_no_we", 32'(got.size()), 32'd0);
    check("hdr40_err_sticky", 32'(err), 32'd1);

    bq = add_chk('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00});
    run_load("recover", bq, 20, -1, stalls);

    bq = '{8'(63)};
    for (int i = 0; i < 252; i++) bq.push_back(8'($urandom));
    bq = add_chk(bq);
    run_load("n63", bq, 0, -1, stalls);
    check("n63_no_backpressure", 32'(stalls), 32'd0);

    bq = '{8'($urandom_range(64, 255))};
    run_load("hdr_big", bq, 0, -1, stalls);

    for (int it = 0; it < 6; it++) begin
      n  = $urandom_range(1, 12);
      bq = '{8'(n)};
      for (int i = 0; i < 4*n; i++) bq.push_back(8'($urandom));
      bq = add_chk(bq);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (it == 4) bq[bq.size()-1] = bq[bq.size()-1] ^ 8'h5A;
`endif
      run_load("rand", bq, 30, (it == 2) ? 3 : -1, stalls);
    end

    // Reset mid-load: fifth byte completes word 0, so mem_we is high when rst hits.
    got.delete();
    pulse_start();
    send_bytes('{8'h03, 8'h11, 8'h22, 8'h33, 8'h44}, 0, -1, stalls);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    bq = add_chk('{8'h01, 8'hA5, 8'h5A, 8'hC3, 8'h3C});
    run_load("after_rst", bq, 10, 2, stalls);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bq = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load("chk_good", bq, 0, -1, stalls);
    bq = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    run_load("chk_bad", bq, 0, -1, stalls);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
